// File: rtl/pipe_pkg.sv
// Shared constants and types for the pipeline control slice.
package pipe_pkg;

  localparam int unsigned PC_INC           = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Source of the next fetch PC, in decreasing priority order.
  typedef enum logic [1:0] {
    PC_SEL_REDIR = 2'd0,
    PC_SEL_HOLD  = 2'd1,
    PC_SEL_PRED  = 2'd2,
    PC_SEL_SEQ   = 2'd3
  } pc_sel_e;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Free-running pipeline performance counters (cycles, stalls, flushes, retires).
// All counters wrap at 2^32 and clear on synchronous active-low reset.
module pipe_perf_cnt (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall,
  input  logic        flush,
  input  logic        retire,
  output logic [31:0] cyc_cnt,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
  output logic [31:0] retire_cnt
);

  // Count events; a stall coincident with a flush is not a stall.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cyc_cnt    <= '0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      retire_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (stall && !flush) stall_cnt <= stall_cnt + 32'd1;
      if (flush)           flush_cnt <= flush_cnt + 32'd1;
      if (retire)          retire_cnt <= retire_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Fetch PC and stage-valid control for a 5-stage pipeline.
// Priority for the next PC: flush (redirect) > stall (hold) > predict > sequential.
// Optional feature: define PIPE_PERF_CNT_EN to add the performance counter ports.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  input  logic                  pred_taken,
  input  logic [DATA_WIDTH-1:0] pred_target,
  output logic [DATA_WIDTH-1:0] pc,
  output logic                  if_id_we,
  output logic                  id_ex_bubble,
  output logic                  if_id_valid,
  output logic                  id_ex_valid,
  output logic                  ex_mem_valid,
  output logic                  mem_wb_valid
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]           cyc_cnt,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           flush_cnt,
  output logic [31:0]           retire_cnt
`endif
);

  pc_sel_e pc_sel;

  // Resolve the next-PC source; flush overrides stall, both override prediction.
  always_comb begin
    pc_sel = PC_SEL_SEQ;
    if (flush)           pc_sel = PC_SEL_REDIR;
    else if (stall)      pc_sel = PC_SEL_HOLD;
    else if (pred_taken) pc_sel = PC_SEL_PRED;
  end

  assign if_id_we     = !stall | flush;
  assign id_ex_bubble = stall | flush;

  // Fetch PC and stage-valid pipeline; reset discards any pending stall/flush.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc           <= RESET_PC;
      if_id_valid  <= 1'b0;
      id_ex_valid  <= 1'b0;
      ex_mem_valid <= 1'b0;
      mem_wb_valid <= 1'b0;
    end else begin
      unique case (pc_sel)
        PC_SEL_REDIR: pc <= redirect_pc;
        PC_SEL_HOLD:  pc <= pc;
        PC_SEL_PRED:  pc <= pred_target;
        default:      pc <= pc + DATA_WIDTH'(PC_INC);
      endcase
      if (flush)      if_id_valid <= 1'b0;
      else if (!stall) if_id_valid <= 1'b1;
      id_ex_valid  <= (flush || stall) ? 1'b0 : if_id_valid;
      ex_mem_valid <= flush ? 1'b0 : id_ex_valid;
      // The instruction in MEM that triggered the flush still retires.
      mem_wb_valid <= ex_mem_valid;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  pipe_perf_cnt u_perf (
    .clk        (clk),
    .rstn       (rstn),
    .stall      (stall),
    .flush      (flush),
    .retire     (mem_wb_valid),
    .cyc_cnt    (cyc_cnt),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt),
    .retire_cnt (retire_cnt)
  );
`else
  // Counters are not built in this configuration.
`endif

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning PC/address width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning PC loaded at reset.
REQ-003 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port stall  input  1  load-use stall request from the hazard unit.
REQ-006 SHALL have port flush  input  1  mispredict/wrong-target flush from the hazard unit.
REQ-007 SHALL have port redirect_pc  input  DATA_WIDTH  correct next PC resolved in MEM.
REQ-008 SHALL have port pred_taken  input  1  IF-stage predictor says taken.
REQ-009 SHALL have port pred_target  input  DATA_WIDTH  IF-stage predicted target.
REQ-010 SHALL have port pc  output  DATA_WIDTH  current fetch PC (registered).
REQ-011 SHALL have port if_id_we  output  1  IF/ID register write enable.
REQ-012 SHALL have port id_ex_bubble  output  1  force ID/EX register to NOP.
REQ-013 SHALL have ports if_id_valid, id_ex_valid, ex_mem_valid, mem_wb_valid  output  1 each  registered stage-valid bits.
REQ-014 SHALL, with PIPE_PERF_CNT_EN defined, have ports cyc_cnt, stall_cnt, flush_cnt, retire_cnt  output  32 each  performance counters.

Function
REQ-015 SHALL update pc at every non-reset edge with priority: flush -> redirect_pc; else stall -> hold; else pred_taken -> pred_target; else pc + 4.
REQ-016 SHALL treat simultaneous stall and flush as flush only; stall ignored that cycle.
REQ-017 SHALL drive if_id_we = !stall | flush and id_ex_bubble = stall | flush, combinationally, same cycle.
REQ-018 SHALL update if_id_valid: flush -> 0; else stall -> hold; else 1.
REQ-019 SHALL update id_ex_valid: flush or stall -> 0; else if_id_valid.
REQ-020 SHALL update ex_mem_valid: flush -> 0; else id_ex_valid.
REQ-021 SHALL update mem_wb_valid <= ex_mem_valid unconditionally; the flushing MEM instruction itself retires.
REQ-022 SHALL produce a one-cycle bubble per stall cycle; an N-cycle stall holds pc and IF/ID for N cycles and inserts N bubbles.
REQ-023 SHALL cause three consecutive invalid slots at MEM/WB after a flush; first valid redirected instruction reaches mem_wb_valid 4 edges after flush edge.
REQ-024 SHALL wrap pc arithmetic modulo 2^DATA_WIDTH (pc = 32'hFFFF_FFFC, no event -> 32'h0000_0000).
REQ-025 SHALL ignore pred_taken/pred_target whenever stall or flush is asserted.

Reset
REQ-026 SHALL, on rising edge with rstn = 0, set pc = RESET_PC, all four valid bits = 0, all counters = 0, regardless of stall/flush.
REQ-027 SHALL, on first edge after rstn returns 1 with no events, set pc = RESET_PC + 4 and if_id_valid = 1.
REQ-028 SHALL, on reset asserted mid-flush or mid-stall, discard the pending event entirely.

Configuration
REQ-029 SHALL, with PIPE_PERF_CNT_EN defined, increment cyc_cnt every non-reset cycle, stall_cnt on stall & !flush, flush_cnt on flush, retire_cnt on mem_wb_valid; all wrap at 2^32.
REQ-030 SHALL, without PIPE_PERF_CNT_EN, omit counter ports and logic; all other behaviour identical.

Structure
REQ-031 SHALL place PC_INC (= 4) and RESET_PC default in shared package pipe_pkg.
REQ-032 SHALL implement counters in sub-module pipe_perf_cnt, instantiated only under PIPE_PERF_CNT_EN.

Verification
REQ-033 SHALL cover reset: rstn = 0 two cycles, release -> pc 0, then 4, 8; if_id_valid 0 then 1.
REQ-034 SHALL cover stall: stall = 1 one cycle at pc = 0x10 -> pc holds 0x10, if_id_we = 0, id_ex_bubble = 1, id_ex_valid = 0 next edge, then pc 0x14.
REQ-035 SHALL cover flush: flush = 1, redirect_pc = 0x200 at pc = 0x40 -> pc = 0x200; if_id/id_ex/ex_mem valid = 0 next edge; mem_wb_valid low for 3 cycles.
REQ-036 SHALL cover stall and flush together, redirect_pc = 0x80 -> pc = 0x80, all front valids 0, stall_cnt unchanged, flush_cnt +1.
REQ-037 SHALL cover prediction: pred_taken = 1, pred_target = 0x100 -> pc = 0x100; same with stall = 1 -> pc holds.
REQ-038 SHALL cover wrap: pc = 0xFFFF_FFFC, no event -> pc = 0x0000_0000; counters (if enabled) preloaded near 2^32-1 wrap to 0.
